// File: rtl/cv32e40x_mpu_tracked.sv
// MPU between a core request port and OBI: region R/W/X checks, outstanding tracking, in-order error responses.
// Optional fault counter enabled by defining CV32E40X_MPU_ERR_CNT_EN (adds err_count_o / err_count_clr_i).
module cv32e40x_mpu_tracked #(
  parameter int                IF_STAGE        = 1,
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                NUM_REGIONS     = 4,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = '{default: '0},
  parameter logic [ADDR_W-1:0] REGION_MASK [NUM_REGIONS] = '{default: '0},
  parameter logic [2:0]        REGION_ATTR [NUM_REGIONS] = '{default: 3'b111},
  parameter logic [2:0]        DEFAULT_ATTR    = 3'b000,
  parameter int                MAX_OUTSTANDING = 2,
  localparam int               CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid_i,
  output logic              core_ready_o,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic              core_we_i,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  input  logic              bus_resp_valid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              core_resp_valid_o,
  output logic [DATA_W-1:0] core_resp_rdata_o,
  output logic [1:0]        core_resp_status_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              mpu_err_o
`ifdef CV32E40X_MPU_ERR_CNT_EN
  ,
  input  logic              err_count_clr_i,
  output logic [7:0]        err_count_o
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ERR_WAIT = 2'd1;
  localparam logic [1:0] ERR_RESP = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_we_q, err_we_d;
  logic [2:0]       attr;
  logic             hit;
  logic             req_we;
  logic             fault;
  logic             fault_accept;
  logic             bus_fire;
  logic             resp_dec;

  // Lowest-indexed matching region decides the attributes.
  always_comb begin
    attr = DEFAULT_ATTR;
    hit  = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && ((core_addr_i & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i]))) begin
        attr = REGION_ATTR[i];
        hit  = 1'b1;
      end
    end
  end

  assign req_we       = (IF_STAGE != 0) ? 1'b0 : core_we_i;
  assign fault        = (IF_STAGE != 0) ? !attr[2] : (req_we ? !attr[1] : !attr[0]);
  assign mpu_err_o    = core_valid_i && fault;
  assign fault_accept = (state_q == IDLE) && core_valid_i && fault;

  assign bus_valid_o  = core_valid_i && (state_q == IDLE) && !fault && (cnt_q < MAX_CNT);
  assign bus_addr_o   = core_addr_i;
  assign bus_we_o     = req_we;
  assign bus_fire     = bus_valid_o && bus_ready_i;
  assign core_ready_o = bus_fire || fault_accept;

  // A response with nothing in flight is ignored so the counter cannot wrap.
  assign resp_dec      = bus_resp_valid_i && (cnt_q != '0);
  assign outstanding_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bus_fire && !resp_dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!bus_fire && resp_dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_we_d = err_we_q;
    case (state_q)
      IDLE: begin
        if (fault_accept) begin
          err_we_d = req_we;
          state_d  = (cnt_d == '0) ? ERR_RESP : ERR_WAIT;
        end
      end
      ERR_WAIT: begin
        if (cnt_d == '0) begin
          state_d = ERR_RESP;
        end
      end
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Nothing is in flight during ERR_RESP, so the error never collides with a bus response.
  always_comb begin
    core_resp_valid_o  = bus_resp_valid_i;
    core_resp_rdata_o  = bus_rdata_i;
    core_resp_status_o = 2'b00;
    if (state_q == ERR_RESP) begin
      core_resp_valid_o  = 1'b1;
      core_resp_rdata_o  = '0;
      core_resp_status_o = err_we_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_we_q <= err_we_d;
    end
  end

`ifdef CV32E40X_MPU_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Clear has priority over a same-cycle fault; the count saturates at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_count_clr_i) begin
      err_cnt_d = '0;
    end else if (fault_accept && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

`ifndef SYNTHESIS
  resp_without_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(bus_resp_valid_i && (cnt_q == '0)));
`endif

endmodule

// File: tb/tb_cv32e40x_mpu_tracked.sv
// Scoreboard bench for cv32e40x_mpu_tracked: random and directed traffic against a memory-map reference model.
module tb_cv32e40x_mpu_tracked;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NR   = 4;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  localparam logic [31:0] RB [NR] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_0000, 32'h3000_0000};
  localparam logic [31:0] RM [NR] = '{32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};
  localparam logic [2:0]  RA [NR] = '{3'b011, 3'b001, 3'b010, 3'b010};

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid_i;
  logic          core_ready_o;
  logic [AW-1:0] core_addr_i;
  logic          core_we_i;
  logic          bus_valid_o;
  logic          bus_ready_i;
  logic [AW-1:0] bus_addr_o;
  logic          bus_we_o;
  logic          bus_resp_valid_i;
  logic [DW-1:0] bus_rdata_i;
  logic          core_resp_valid_o;
  logic [DW-1:0] core_resp_rdata_o;
  logic [1:0]    core_resp_status_o;
  logic [CW-1:0] outstanding_o;
  logic          mpu_err_o;
`ifdef CV32E40X_MPU_ERR_CNT_EN
  logic          err_count_clr_i;
  logic [7:0]    err_count_o;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] pendQ[$];
  resp_t       expQ[$];
  bit          errPending = 1'b0;
  int          faultCnt = 0;
  bit          clrNext = 1'b0;

  cv32e40x_mpu_tracked #(
    .IF_STAGE(0), .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR),
    .REGION_BASE(RB), .REGION_MASK(RM), .REGION_ATTR(RA),
    .DEFAULT_ATTR(3'b000), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_resp_valid_i(bus_resp_valid_i), .bus_rdata_i(bus_rdata_i),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_rdata_o(core_resp_rdata_o),
    .core_resp_status_o(core_resp_status_o), .outstanding_o(outstanding_o),
    .mpu_err_o(mpu_err_o)
`ifdef CV32E40X_MPU_ERR_CNT_EN
    , .err_count_clr_i(err_count_clr_i), .err_count_o(err_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory map as seen by software: 0x0 RAM (RW), 0x1 ROM (R, shadows a W window), 0x3 write-only, rest unmapped.
  function automatic bit modelFault(input logic [31:0] a, input logic w);
    case (a[31:28])
      4'h0:    return 1'b0;
      4'h1:    return w;
      4'h3:    return !w;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] busData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] r;
    logic [3:0]  nib;
    r = $urandom();
    case ($urandom_range(4))
      0:       nib = 4'h0;
      1:       nib = 4'h1;
      2:       nib = 4'h3;
      3:       nib = 4'h2;
      default: nib = 4'hC;
    endcase
    if ($urandom_range(1) == 1) r[27:24] = 4'h0;
    return {nib, r[27:0]};
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(output bit acc);
    bit f, expBv, expRdy, expErr;
    @(negedge clk);
    f      = modelFault(core_addr_i, core_we_i);
    expBv  = core_valid_i && !errPending && !f && (pendQ.size() < MAXO);
    expRdy = (expBv && bus_ready_i) || (core_valid_i && !errPending && f);
    expErr = errPending && (pendQ.size() == 0);
    compare("mpu_err", 64'(mpu_err_o), 64'(core_valid_i && f));
    compare("bus_valid", 64'(bus_valid_o), 64'(expBv));
    compare("core_ready", 64'(core_ready_o), 64'(expRdy));
    compare("resp_valid", 64'(core_resp_valid_o), 64'(expErr || bus_resp_valid_i));
    compare("outstanding", 64'(outstanding_o), 64'(pendQ.size()));
    if (expBv) begin
      compare("bus_addr", 64'(bus_addr_o), 64'(core_addr_i));
      compare("bus_we", 64'(bus_we_o), 64'(core_we_i));
    end
`ifdef CV32E40X_MPU_ERR_CNT_EN
    compare("err_count", 64'(err_count_o), 64'(faultCnt));
`endif
    if (bus_resp_valid_i) void'(pendQ.pop_front());
    if (expErr) errPending = 1'b0;
    acc = expRdy;
    if (expRdy) begin
      if (f) begin
        errPending = 1'b1;
        expQ.push_back({core_we_i ? 2'b10 : 2'b01, 32'h0});
      end else begin
        pendQ.push_back(core_addr_i);
        expQ.push_back({2'b00, busData(core_addr_i)});
      end
    end
    if (clrNext) faultCnt = 0;
    else if (expRdy && f && faultCnt < 255) faultCnt++;
  endtask

  task automatic applyStimulus(input bit cv, input logic [31:0] a, input bit w,
                               input bit rdy, input bit rsp, output bit acc);
    @(posedge clk);
    #1;
    core_valid_i     = cv;
    core_addr_i      = a;
    core_we_i        = w;
    bus_ready_i      = rdy;
    bus_resp_valid_i = rsp && (pendQ.size() > 0);
    bus_rdata_i      = bus_resp_valid_i ? busData(pendQ[0]) : 32'h0;
`ifdef CV32E40X_MPU_ERR_CNT_EN
    err_count_clr_i  = clrNext;
`endif
    checkOutput(acc);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    core_valid_i = 1'b0;
    bus_ready_i = 1'b0;
    bus_resp_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pendQ.delete();
    expQ.delete();
    errPending = 1'b0;
    faultCnt = 0;
  endtask

  // Scoreboard monitor: every response the core sees must be the oldest expected one.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && core_resp_valid_o) begin
      if (expQ.size() == 0) begin
        compare("resp_unexpected", 64'(core_resp_valid_o), 64'(0));
      end else begin
        e = expQ.pop_front();
        compare("resp_status", 64'(core_resp_status_o), 64'(e.status));
        compare("resp_rdata", 64'(core_resp_rdata_o), 64'(e.data));
      end
    end
  end

  initial begin
    bit acc;
    bit hold;
    logic [31:0] hAddr;
    bit hWe;
    rst = 1'b1;
    core_valid_i = 1'b0;
    core_addr_i = '0;
    core_we_i = 1'b0;
    bus_ready_i = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_rdata_i = '0;
`ifdef CV32E40X_MPU_ERR_CNT_EN
    err_count_clr_i = 1'b0;
`endif
    doReset();
    applyStimulus(0, 32'h0, 0, 0, 0, acc);

    // Allowed read, then a store fault with nothing in flight.
    applyStimulus(1, 32'h0000_0010, 0, 1, 0, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);
    applyStimulus(1, 32'h2000_0000, 1, 0, 0, acc);
    applyStimulus(0, 32'h0, 0, 0, 0, acc);

    // Read fault behind two in-flight reads, with a request held during the wait.
    applyStimulus(1, 32'h0000_0100, 0, 1, 0, acc);
    applyStimulus(1, 32'h1000_0200, 0, 1, 0, acc);
    applyStimulus(1, 32'h4000_0000, 0, 1, 0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h0000_0300, 0, 1, i < 2, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);

    // Outstanding limit, then accept-and-respond in the same cycle.
    applyStimulus(1, 32'h0000_0010, 0, 1, 0, acc);
    applyStimulus(1, 32'h0000_0020, 0, 1, 0, acc);
    applyStimulus(1, 32'h0000_0030, 0, 1, 0, acc);
    applyStimulus(1, 32'h0000_0030, 0, 1, 1, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);
    applyStimulus(1, 32'h3000_0040, 1, 1, 0, acc);
    applyStimulus(1, 32'h0000_0050, 1, 1, 1, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);

    // Reset while waiting on in-flight traffic drops the pending error.
    applyStimulus(1, 32'h0000_0100, 0, 1, 0, acc);
    applyStimulus(1, 32'h0000_0200, 0, 1, 0, acc);
    applyStimulus(1, 32'h1000_0000, 1, 1, 0, acc);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 1, 0, acc);
    applyStimulus(1, 32'h0000_0400, 0, 1, 0, acc);
    applyStimulus(0, 32'h0, 0, 1, 1, acc);

    hold = 1'b0;
    hAddr = '0;
    hWe = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!hold && $urandom_range(99) < 65) begin
        hold = 1'b1;
        hAddr = randAddr();
        hWe = 1'($urandom_range(1));
      end
      applyStimulus(hold, hAddr, hWe, $urandom_range(99) < 70, $urandom_range(99) < 40, acc);
      if (acc) hold = 1'b0;
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 0, 1, 1, acc);

`ifdef CV32E40X_MPU_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 32'h2000_0000, 1, 0, 0, acc);
      applyStimulus(0, 32'h0, 0, 0, 0, acc);
    end
    clrNext = 1'b1;
    applyStimulus(1, 32'h2000_0000, 1, 0, 0, acc);
    clrNext = 1'b0;
    applyStimulus(0, 32'h0, 0, 0, 0, acc);
    applyStimulus(0, 32'h0, 0, 0, 0, acc);
`endif

    compare("scoreboard_drained", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
